// File: rtl/comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding
// and the slice-count helper.
package comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int SLICE_DEF = 1;
  // Slice count for the default configuration; instances derive their own
  // value from calc_nslice so that non-default parameters stay consistent.
  localparam int NSLICE = WIDTH_DEF / SLICE_DEF;

  function automatic int calc_nslice(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/slice_compare.sv
// Combinational magnitude compare of one SLICE-bit chunk of the two operands.
module slice_compare #(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  output logic             o_g,
  output logic             o_l,
  output logic             o_e
);

  assign o_g = (i_a > i_b);
  assign o_l = (i_a < i_b);
  assign o_e = (i_a == i_b);

endmodule

// File: rtl/serial_mag_comparator.sv
// Serial MSB-first magnitude comparator: walks the operands SLICE bits per
// cycle and stops at the first differing slice.
//
// state   | meaning
// IDLE    | waiting for start_in, operands sampled on acceptance
// RUN     | comparing slice r_idx of the latched operands
// DONE    | result valid, done_out high for exactly this cycle
module serial_mag_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             signed_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             g_out,
  output logic             l_out,
  output logic             e_out
);

  localparam int NUM_SLICES = calc_nslice(WIDTH, SLICE);
  localparam int IDXW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NUM_SLICES - 1);
  localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

  generate
    if (((WIDTH % SLICE) != 0) || (WIDTH < 2)) begin : g_bad_cfg
      $error("serial_mag_comparator: WIDTH must be >= 2 and a multiple of SLICE");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [IDXW-1:0]  r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_g;
  logic             r_l;
  logic             r_e;

  logic             w_flip;
  logic [SLICE-1:0] w_a_slice;
  logic [SLICE-1:0] w_b_slice;
  logic             w_g;
  logic             w_l;
  logic             w_e;

  // Operands shift left as slices retire, so the current slice is always the
  // top SLICE bits. Sign handling flips the operand MSB only on slice 0.
  assign w_flip    = r_signed && (r_idx == '0);
  assign w_a_slice = r_a[WIDTH-1 -: SLICE] ^ (w_flip ? MSB_MASK : '0);
  assign w_b_slice = r_b[WIDTH-1 -: SLICE] ^ (w_flip ? MSB_MASK : '0);

  slice_compare #(
    .SLICE(SLICE)
  ) u_slice_compare (
    .i_a(w_a_slice),
    .i_b(w_b_slice),
    .o_g(w_g),
    .o_l(w_l),
    .o_e(w_e)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_g      <= 1'b0;
      r_l      <= 1'b0;
      r_e      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start_in) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_signed <= signed_in;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!w_e) begin
            r_g     <= w_g;
            r_l     <= w_l;
            r_e     <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (r_idx == LAST_IDX) begin
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_e     <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
            r_a   <= r_a << SLICE;
            r_b   <= r_b << SLICE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_out = r_busy;
  assign done_out = r_done;
  assign g_out    = r_g;
  assign l_out    = r_l;
  assign e_out    = r_e;

endmodule
